// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus the valid/ready holding-register port of spi_slave_rx.
// slave  = the receiver's view (spi_slave_rx itself).
// master = the environment's view (pad ring driving SPI, consumer reading words).
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  ss_n;
  logic                  mosi;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  overrun;
  logic                  frame_err;
  logic                  parity_err;
  logic                  busy;

  modport slave (
    input  sclk, ss_n, mosi, rx_ready,
    output rx_data, rx_valid, overrun, frame_err, parity_err, busy
  );

  modport master (
    output sclk, ss_n, mosi, rx_ready,
    input  rx_data, rx_valid, overrun, frame_err, parity_err, busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 peripheral receiver, oversampled on clk.
// SCLK, ss_n and MOSI are synchronized (2 flops) plus one history flop, edges
// are detected in the clk domain, and words are deserialized into a
// valid/ready holding register.
// Optional feature macro: SPI_RX_PARITY_EN -- each word carries a trailing
// even-parity bit that is checked and stripped before delivery.
module spi_slave_rx #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

`ifdef SPI_RX_PARITY_EN
  localparam int WORD_BITS = DATA_WIDTH + 1;
`else
  localparam int WORD_BITS = DATA_WIDTH;
`endif
  localparam int CNT_W = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t state, state_d;

  // Synchronizer and history flops.
  logic sclk_meta, sclk_sync, sclk_hist;
  logic ss_meta,   ss_sync,   ss_hist;
  logic mosi_meta, mosi_sync;

  logic sclk_rise, ss_fall, ss_rise;

  logic [CNT_W-1:0]     bit_cnt, cnt_d;
  logic [WORD_BITS-1:0] shreg, shift_in;
  logic [DATA_WIDTH-1:0] word_data;

  logic shift_en, commit, frame_abort;

  logic [DATA_WIDTH-1:0] rx_data_q;
  logic rx_valid_q, overrun_q, frame_err_q;

  // Bring the asynchronous SPI pins into the clk domain and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_hist <= 1'b0;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_hist   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= bus.sclk;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      ss_meta   <= bus.ss_n;
      ss_sync   <= ss_meta;
      ss_hist   <= ss_sync;
      // MOSI has the same two-flop depth as SCLK so the sampled bit lines up with sclk_rise.
      mosi_meta <= bus.mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_hist;
  assign ss_fall   = ~ss_sync & ss_hist;
  assign ss_rise   = ss_sync & ~ss_hist;

  // Shift register contents after accepting the current MOSI bit.
  always_comb begin
    if (LSB_FIRST) begin
      shift_in = {mosi_sync, shreg[WORD_BITS-1:1]};
    end else begin
      shift_in = {shreg[WORD_BITS-2:0], mosi_sync};
    end
  end

  // Data field of the completed word; any parity bit sits at the end of the received sequence.
  assign word_data = LSB_FIRST ? shift_in[DATA_WIDTH-1:0]
                               : shift_in[WORD_BITS-1:WORD_BITS-DATA_WIDTH];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and control decode: shift first, then judge ss_rise against the post-shift count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state;
    cnt_d       = bit_cnt;
    shift_en    = 1'b0;
    commit      = 1'b0;
    frame_abort = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (ss_fall) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            commit = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = bit_cnt + CNT_W'(1);
          end
        end
        // NOTE: blocking assignments here are deliberate; cnt_d is read back below as the post-shift count.
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_d != '0) begin
            frame_abort = 1'b1;
            cnt_d       = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, shift register, holding register and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt     <= cnt_d;
      overrun_q   <= 1'b0;
      frame_err_q <= frame_abort;
      if (shift_en) begin
        shreg <= shift_in;
      end
      if (commit) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= word_data;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_RX_PARITY_EN
  logic parity_err_q;

  // Even parity over data plus parity bit; flagged on every commit, delivered or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= commit & (^shift_in);
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state == RECV);

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: self-checking bench for spi_slave_rx.
// Two receivers share the SPI pins: an MSB-first one with a driven rx_ready
// (scoreboarded on every accepted word) and an LSB-first one with rx_ready tied high.
module tb_spi_slave_rx;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_rx_if #(.DATA_WIDTH(DW)) bus ();
  spi_slave_rx_if #(.DATA_WIDTH(DW)) bus_lsb ();

  spi_slave_rx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  spi_slave_rx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsb)
  );

  assign bus_lsb.sclk     = bus.sclk;
  assign bus_lsb.ss_n     = bus.ss_n;
  assign bus_lsb.mosi     = bus.mosi;
  assign bus_lsb.rx_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard and event counters, sampled on the falling clk edge.
  logic [DW-1:0] sb[$];
  int n_acc  = 0;
  int n_ovr  = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_lsb  = 0;
  logic [DW-1:0] lsb_last = '0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.overrun)    n_ovr++;
      if (bus.frame_err)  n_ferr++;
      if (bus.parity_err) n_perr++;
      if (bus.rx_valid && bus.rx_ready) begin
        n_acc++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word 0x%0h, expected no word", bus.rx_data);
        end else begin
          check("sb_word", 32'(bus.rx_data), 32'(sb.pop_front()));
        end
      end
      if (bus_lsb.rx_valid) begin
        n_lsb++;
        lsb_last = bus_lsb.rx_data;
      end
    end
  end

  // One SPI mode-0 bit: MOSI set while SCLK is low, 4 clk periods per half SCLK period.
  task automatic spi_bit(input logic b);
    bus.mosi = b;
    #40;
    bus.sclk = 1'b1;
    #40;
    bus.sclk = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) spi_bit(w[i]);
`ifdef SPI_RX_PARITY_EN
    spi_bit(^w);
`endif
  endtask

`ifdef SPI_RX_PARITY_EN
  task automatic send_word_par(input logic [DW-1:0] w, input logic par);
    for (int i = DW - 1; i >= 0; i--) spi_bit(w[i]);
    spi_bit(par);
  endtask
`endif

  task automatic frame_start();
    @(posedge clk);
    #1;
    bus.ss_n = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40;
    bus.ss_n = 1'b1;
    #100;
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    logic [DW-1:0] exp_msb;
    logic [DW-1:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  int acc0, ovr0, ferr0, perr0, lsb0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{tx: 8'h01, exp_msb: 8'h01, exp_lsb: 8'h80};
    vecs[1] = '{tx: 8'hF0, exp_msb: 8'hF0, exp_lsb: 8'h0F};
    vecs[2] = '{tx: 8'h35, exp_msb: 8'h35, exp_lsb: 8'hAC};
    vecs[3] = '{tx: 8'hC8, exp_msb: 8'hC8, exp_lsb: 8'h13};
    vecs[4] = '{tx: 8'h00, exp_msb: 8'h00, exp_lsb: 8'h00};
    vecs[5] = '{tx: 8'hFF, exp_msb: 8'hFF, exp_lsb: 8'hFF};

    bus.sclk     = 1'b0;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.rx_ready = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data",    32'(bus.rx_data), 32'h0);
    check("rst_rx_valid",   32'(bus.rx_valid), 32'h0);
    check("rst_busy",       32'(bus.busy), 32'h0);
    check("rst_overrun",    32'(bus.overrun), 32'h0);
    check("rst_frame_err",  32'(bus.frame_err), 32'h0);
    check("rst_parity_err", 32'(bus.parity_err), 32'h0);
    rst = 1'b1;
    #20;

    // Single word 0xA5, held with rx_ready low, then accepted.
    acc0 = n_acc; ovr0 = n_ovr; ferr0 = n_ferr;
    sb.push_back(8'hA5);
    frame_start();
    check("single_busy_high", 32'(bus.busy), 32'h1);
    send_word(8'hA5);
    frame_end();
    check("single_valid",   32'(bus.rx_valid), 32'h1);
    check("single_data",    32'(bus.rx_data), 32'hA5);
    check("single_busy_low", 32'(bus.busy), 32'h0);
    check("single_no_ovr",  32'(n_ovr - ovr0), 32'h0);
    check("single_no_ferr", 32'(n_ferr - ferr0), 32'h0);
    bus.rx_ready = 1'b1;
    #30;
    check("single_valid_fall", 32'(bus.rx_valid), 32'h0);
    check("single_acc",        32'(n_acc - acc0), 32'h1);

    // Back-to-back words in one frame with rx_ready held high.
    acc0 = n_acc; ovr0 = n_ovr;
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    frame_start();
    send_word(8'h3C);
    send_word(8'hC3);
    frame_end();
    check("b2b_acc",    32'(n_acc - acc0), 32'h2);
    check("b2b_no_ovr", 32'(n_ovr - ovr0), 32'h0);

    // Table of single-word frames, checked on both bit orders.
    for (int i = 0; i < 6; i++) begin
      lsb0 = n_lsb;
      sb.push_back(vecs[i].exp_msb);
      frame_start();
      send_word(vecs[i].tx);
      frame_end();
      check($sformatf("vec%0d_lsb_cnt", i),  32'(n_lsb - lsb0), 32'h1);
      check($sformatf("vec%0d_lsb_data", i), 32'(lsb_last), 32'(vecs[i].exp_lsb));
    end

    // Overrun: second word is dropped while the first is still held.
    bus.rx_ready = 1'b0;
    acc0 = n_acc; ovr0 = n_ovr;
    sb.push_back(8'h11);
    frame_start();
    send_word(8'h11);
    send_word(8'h22);
    frame_end();
    check("ovr_pulse", 32'(n_ovr - ovr0), 32'h1);
    check("ovr_data",  32'(bus.rx_data), 32'h11);
    check("ovr_valid", 32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    #30;
    check("ovr_valid_fall", 32'(bus.rx_valid), 32'h0);
    check("ovr_acc",        32'(n_acc - acc0), 32'h1);

    // Frame error: 5 SCLK pulses then ss_n high.
    bus.rx_ready = 1'b0;
    acc0 = n_acc; ferr0 = n_ferr; lsb0 = n_lsb;
    frame_start();
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    frame_end();
    check("ferr_pulse",    32'(n_ferr - ferr0), 32'h1);
    check("ferr_no_valid", 32'(bus.rx_valid), 32'h0);
    check("ferr_lsb_none", 32'(n_lsb - lsb0), 32'h0);
    check("ferr_busy_low", 32'(bus.busy), 32'h0);
    bus.rx_ready = 1'b1;
    sb.push_back(8'h5A);
    frame_start();
    send_word(8'h5A);
    frame_end();
    check("ferr_next_acc", 32'(n_acc - acc0), 32'h1);

    // SCLK noise with ss_n high must not disturb anything.
    acc0 = n_acc; ferr0 = n_ferr; lsb0 = n_lsb;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) spi_bit(1'b1);
    #60;
    check("noise_busy",  32'(bus.busy), 32'h0);
    check("noise_acc",   32'(n_acc - acc0), 32'h0);
    check("noise_ferr",  32'(n_ferr - ferr0), 32'h0);
    check("noise_lsb",   32'(n_lsb - lsb0), 32'h0);

    // Reset after 3 bits of a word.
    ferr0 = n_ferr;
    frame_start();
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    rst = 1'b0;
    #20;
    check("mrst_rx_data",  32'(bus.rx_data), 32'h0);
    check("mrst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("mrst_busy",     32'(bus.busy), 32'h0);
    bus.ss_n = 1'b1;
    #20;
    rst = 1'b1;
    #40;
    check("mrst_busy_after", 32'(bus.busy), 32'h0);
    check("mrst_no_ferr",    32'(n_ferr - ferr0), 32'h0);
    acc0 = n_acc;
    sb.push_back(8'hFF);
    frame_start();
    send_word(8'hFF);
    frame_end();
    check("mrst_next_acc", 32'(n_acc - acc0), 32'h1);

`ifdef SPI_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1.
    perr0 = n_perr;
    sb.push_back(8'h07);
    frame_start();
    send_word_par(8'h07, 1'b1);
    frame_end();
    check("par_ok", 32'(n_perr - perr0), 32'h0);
    perr0 = n_perr;
    sb.push_back(8'h07);
    frame_start();
    send_word_par(8'h07, 1'b0);
    frame_end();
    check("par_bad",      32'(n_perr - perr0), 32'h1);
    check("par_bad_data", 32'(bus.rx_data), 32'h07);
`else
    perr0 = 0;
    check("no_parity_err", 32'(n_perr - perr0), 32'h0);
`endif

    #50;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
